// File: rtl/n4_b2_down_counter_pkg.sv
// Shared definitions for the base-2 down counter family.
package n4_b2_down_counter_pkg;

   // Default and maximum counter width (number of base-2 digits).
   localparam int unsigned CNT_N_DEFAULT = 4;
   localparam int unsigned CNT_N_MAX     = 16;

   // Count direction codes shared with the up-counter counterpart.
   typedef enum logic {
      COUNT_DOWN = 1'b0,
      COUNT_UP   = 1'b1
   } count_dir_e;

   localparam count_dir_e CNT_DIR = COUNT_DOWN;

endpackage : n4_b2_down_counter_pkg

// File: rtl/n4_b2_down_counter_digit.sv
// One base-2 down-count digit: toggles on borrow-in, presets on load.
module b2_down_digit (
   input  logic clk_i,
   input  logic rst_i,
   input  logic bi_i,
   input  logic load_i,
   input  logic d_i,
   output logic q_o,
   output logic bo_o
);

   logic q_q;
   logic q_d;

   // Next state: load wins, otherwise toggle when a borrow arrives.
   always_comb begin
      q_d = q_q ^ bi_i;
      if (load_i) begin
         q_d = d_i;
      end
   end

   // Digit state register with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o  = q_q;
   // A digit at 0 passes the borrow on to the next higher digit.
   assign bo_o = bi_i & ~q_q;

endmodule : b2_down_digit

// File: rtl/n4_b2_down_counter.sv
// N-digit base-2 down counter with parallel load and cascadable borrow.
module n4_b2_down_counter
   import n4_b2_down_counter_pkg::*;
#(
   parameter int unsigned N = CNT_N_DEFAULT  // legal range 1..16
) (
   input  logic         m_clock,
   input  logic         m_reset,
   input  logic         m_ei,
   input  logic         m_load,
   input  logic [N-1:0] m_d,
   output logic         eu,
   output logic [N-1:0] q,
   output logic         zero
);

   // Ripple borrow chain: borrow[0] is the enable, borrow[N] means all digits were 0.
   logic [N:0] borrow;

   assign borrow[0] = m_ei;

   // One digit per bit, borrow rippling from LSB to MSB.
   for (genvar gi = 0; gi < int'(N); gi++) begin : g_digit
      b2_down_digit u_digit (
         .clk_i  (m_clock),
         .rst_i  (m_reset),
         .bi_i   (borrow[gi]),
         .load_i (m_load),
         .d_i    (m_d[gi]),
         .q_o    (q[gi]),
         .bo_o   (borrow[gi+1])
      );
   end

   // Borrow-out is suppressed when a load overrides the decrement.
   assign eu   = borrow[N] & ~m_load;
   // Zero flag depends on the state register only.
   assign zero = ~|q;

endmodule : n4_b2_down_counter

// File: tb/tb_n4_b2_down_counter.sv
// Scoreboard bench for the N=4 down counter and an 8-bit cascade of two.
module tb_n4_b2_down_counter;

   typedef struct {
      bit         casc;
      logic [7:0] q;
      logic       z;
      logic       eu;
   } exp_t;

   logic       clk;
   logic       m_reset;
   logic       m_ei;
   logic       m_load;
   logic [3:0] m_d;
   logic       eu;
   logic [3:0] q;
   logic       zero;

   logic       c_ei;
   logic       c_load;
   logic [7:0] c_d;
   logic [3:0] lo_q, hi_q;
   logic       lo_eu, hi_eu, lo_zero, hi_zero;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   n4_b2_down_counter #(.N(4)) dut (
      .m_clock (clk),
      .m_reset (m_reset),
      .m_ei    (m_ei),
      .m_load  (m_load),
      .m_d     (m_d),
      .eu      (eu),
      .q       (q),
      .zero    (zero)
   );

   n4_b2_down_counter #(.N(4)) u_lo (
      .m_clock (clk),
      .m_reset (m_reset),
      .m_ei    (c_ei),
      .m_load  (c_load),
      .m_d     (c_d[3:0]),
      .eu      (lo_eu),
      .q       (lo_q),
      .zero    (lo_zero)
   );

   n4_b2_down_counter #(.N(4)) u_hi (
      .m_clock (clk),
      .m_reset (m_reset),
      .m_ei    (lo_eu),
      .m_load  (c_load),
      .m_d     (c_d[7:4]),
      .eu      (hi_eu),
      .q       (hi_q),
      .zero    (hi_zero)
   );

   initial begin
      clk = 1'b0;
      #3;
      forever #5 clk = ~clk;
   end

   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Monitor: one expected entry is consumed per cycle, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (!e.casc) begin
            cmp("q", {4'h0, q}, e.q);
            cmp("zero", {7'h0, zero}, {7'h0, e.z});
            cmp("eu", {7'h0, eu}, {7'h0, e.eu});
         end else begin
            cmp("casc_q", {hi_q, lo_q}, e.q);
            cmp("casc_zero", {7'h0, lo_zero & hi_zero}, {7'h0, e.z});
            cmp("casc_eu", {7'h0, hi_eu}, {7'h0, e.eu});
         end
      end
   end

   task automatic push(input bit casc, input logic [7:0] eq, input logic ez, input logic eeu);
      exp_t e;
      e.casc = casc;
      e.q    = eq;
      e.z    = ez;
      e.eu   = eeu;
      sb.push_back(e);
   endtask

   // Drive one cycle of main-counter inputs and record what that cycle must show.
   task automatic cyc(input logic ei, input logic ld, input logic [3:0] d,
                      input logic [3:0] eq, input logic ez, input logic eeu);
      @(posedge clk);
      #1;
      m_ei   = ei;
      m_load = ld;
      m_d    = d;
      push(1'b0, {4'h0, eq}, ez, eeu);
   endtask

   // Same for the cascaded pair.
   task automatic ccyc(input logic ei, input logic ld, input logic [7:0] d,
                       input logic [7:0] eq, input logic ez, input logic eeu);
      @(posedge clk);
      #1;
      c_ei   = ei;
      c_load = ld;
      c_d    = d;
      push(1'b1, eq, ez, eeu);
   endtask

   initial begin
      logic [3:0] e;
      m_reset = 1'b1;
      m_ei    = 1'b0;
      m_load  = 1'b0;
      m_d     = 4'h0;
      c_ei    = 1'b0;
      c_load  = 1'b0;
      c_d     = 8'h00;
      #10;
      m_reset = 1'b0;

      // Reset state holds with enable low.
      repeat (5) cyc(1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

      // Free-running decrement from 0 through the wrap back to 0.
      for (int k = 0; k <= 16; k++) begin
         e = 4'((16 - k) % 16);
         cyc(1'b1, 1'b0, 4'h0, e, e == 4'h0, e == 4'h0);
      end

      // Load 9 (q is 15 after the last wrap), then count to 0 and wrap to 15.
      cyc(1'b0, 1'b1, 4'd9, 4'd15, 1'b0, 1'b0);
      for (int k = 0; k <= 9; k++) begin
         e = 4'(9 - k);
         cyc(1'b1, 1'b0, 4'h0, e, e == 4'h0, e == 4'h0);
      end
      cyc(1'b0, 1'b0, 4'h0, 4'd15, 1'b0, 1'b0);

      // Load and enable together at q=0: no borrow-out, load wins.
      cyc(1'b0, 1'b1, 4'd0, 4'd15, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 4'd0, 4'd5, 1'b0, 1'b0);

      // Count down from 12, hold at 7, then reset asynchronously mid-cycle.
      cyc(1'b0, 1'b1, 4'd12, 4'd5, 1'b0, 1'b0);
      for (int k = 0; k <= 4; k++) begin
         cyc(1'b1, 1'b0, 4'h0, 4'(12 - k), 1'b0, 1'b0);
      end
      cyc(1'b0, 1'b0, 4'h0, 4'd7, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      m_ei = 1'b1;
      #1;
      m_reset = 1'b1;
      push(1'b0, 8'h00, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      m_reset = 1'b0;
      push(1'b0, 8'h00, 1'b1, 1'b1);
      cyc(1'b1, 1'b0, 4'h0, 4'd15, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 4'h0, 4'd14, 1'b0, 1'b0);

      // Cascade: load 8'h01 and decrement through the 8-bit wrap.
      ccyc(1'b0, 1'b1, 8'h01, 8'h00, 1'b1, 1'b0);
      ccyc(1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 1'b0);
      ccyc(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
      ccyc(1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
      ccyc(1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0);
      ccyc(1'b0, 1'b0, 8'h00, 8'hFD, 1'b0, 1'b0);

      // Let the monitor drain, with a bounded wait.
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_n4_b2_down_counter
